// File: rtl/tetris_pkg.sv
// Shared piece and FSM types for the 7-bag piece scheduler.
package tetris_pkg;

  typedef enum logic [2:0] {
    I = 3'd0,
    O = 3'd1,
    T = 3'd2,
    S = 3'd3,
    Z = 3'd4,
    J = 3'd5,
    L = 3'd6
  } piece_e;

  localparam int num_pieces_lp = 7;

  typedef enum logic {
    S_DRAW = 1'b0,
    S_FULL = 1'b1
  } state_e;

  function automatic logic [2:0] lowest_clear(input logic [6:0] mask);
    lowest_clear = 3'd0;
    for (int k = num_pieces_lp - 1; k >= 0; k--) begin
      if (!mask[k]) lowest_clear = 3'(k);
    end
  endfunction

  function automatic logic [2:0] popcount7(input logic [6:0] mask);
    popcount7 = 3'd0;
    for (int k = 0; k < num_pieces_lp; k++) begin
      popcount7 = popcount7 + {2'b00, mask[k]};
    end
  endfunction

endpackage

// File: rtl/piece_queue.sv
// 2-entry piece FIFO: head and second slots, push visible the cycle after the edge.
// Pop and push may share an edge; caller never pushes into a full queue without popping.
module piece_queue
  import tetris_pkg::*;
(
  input  logic   clk_i,
  input  logic   reset_n_i,
  input  logic   i_push,
  input  piece_e i_push_dat,
  input  logic   i_pop,
  output piece_e o_head_dat,
  output logic   o_head_vld,
  output piece_e o_second_dat,
  output logic   o_second_vld
);

  piece_e r_head;
  piece_e r_second;
  logic   r_head_vld;
  logic   r_second_vld;
  logic   w_pop;

  assign w_pop = i_pop & r_head_vld;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head       <= I;
      r_second     <= I;
      r_head_vld   <= 1'b0;
      r_second_vld <= 1'b0;
    end else if (w_pop) begin
      if (i_push) begin
        if (r_second_vld) begin
          r_head   <= r_second;
          r_second <= i_push_dat;
        end else begin
          r_head <= i_push_dat;
        end
      end else begin
        // Empty slots are parked at zero so the outputs read 0 when invalid.
        r_head       <= r_second;
        r_head_vld   <= r_second_vld;
        r_second     <= I;
        r_second_vld <= 1'b0;
      end
    end else if (i_push) begin
      if (!r_head_vld) begin
        r_head     <= i_push_dat;
        r_head_vld <= 1'b1;
      end else begin
        r_second     <= i_push_dat;
        r_second_vld <= 1'b1;
      end
    end
  end

  assign o_head_dat   = r_head;
  assign o_head_vld   = r_head_vld;
  assign o_second_dat = r_second;
  assign o_second_vld = r_second_vld;

endmodule

// File: rtl/piece_bag_scheduler.sv
// Draws a fair 7-bag piece stream from a random word; one piece per cycle, retry_max_p+1 worst case.
// A full 2-entry queue stalls drawing, freezing bag and retry state until the head is taken.
module piece_bag_scheduler
  import tetris_pkg::*;
#(
  parameter int rand_width_p = 65,
  parameter int sel_lsb_p    = 0,
  parameter int retry_max_p  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [rand_width_p-1:0] rand_i,
  output piece_e                  piece_o,
  output logic                    piece_valid_o,
  input  logic                    piece_ready_i,
  output piece_e                  preview_o,
  output logic                    preview_valid_o,
  output logic [2:0]              bag_count_o
);

  logic [6:0] r_bag_used;
  logic [3:0] r_retry;
  state_e     r_state;

  logic       w_head_vld;
  logic       w_second_vld;
  logic       w_pop;
  logic       w_draw;
  logic [2:0] w_cand;
  logic [7:0] w_used_ext;
  logic       w_forced;
  logic       w_accept;
  piece_e     w_piece;
  logic [6:0] w_bag_set;
  logic [6:0] w_bag_next;
  logic [1:0] w_occ;
  logic [1:0] w_occ_next;
  logic       w_unused_rand;

  assign w_unused_rand = ^rand_i;

  assign w_pop    = w_head_vld & piece_ready_i;
  assign w_draw   = (r_state == S_DRAW) | w_pop;
  assign w_cand   = rand_i[sel_lsb_p +: 3];
  // Slot 7 is permanently marked used so an out-of-range candidate rejects like a repeat.
  assign w_used_ext = {1'b1, r_bag_used};
  assign w_forced = (r_retry == 4'(retry_max_p));
  assign w_accept = w_draw & (w_forced | ~w_used_ext[w_cand]);
  assign w_piece  = w_forced ? piece_e'(lowest_clear(r_bag_used)) : piece_e'(w_cand);

  assign w_bag_set  = r_bag_used | (7'd1 << w_piece);
  assign w_bag_next = (&w_bag_set) ? 7'd0 : w_bag_set;

  assign w_occ      = {1'b0, w_head_vld} + {1'b0, w_second_vld};
  assign w_occ_next = w_occ + {1'b0, w_accept} - {1'b0, w_pop};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_bag_used <= 7'd0;
      r_retry    <= 4'd0;
      r_state    <= S_DRAW;
    end else begin
      if (w_accept) begin
        r_bag_used <= w_bag_next;
        r_retry    <= 4'd0;
      end else if (w_draw) begin
        r_retry <= r_retry + 4'd1;
      end
      r_state <= (w_occ_next == 2'd2) ? S_FULL : S_DRAW;
    end
  end

  piece_queue u_queue (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .i_push       (w_accept),
    .i_push_dat   (w_piece),
    .i_pop        (piece_ready_i),
    .o_head_dat   (piece_o),
    .o_head_vld   (w_head_vld),
    .o_second_dat (preview_o),
    .o_second_vld (w_second_vld)
  );

  assign piece_valid_o   = w_head_vld;
  assign preview_valid_o = w_second_vld;
  assign bag_count_o     = popcount7(r_bag_used);

endmodule

// File: tb/tb_piece_bag_scheduler.sv
// Bench for piece_bag_scheduler: directed scenarios then random stimulus against a queue/bag model.
module tb_piece_bag_scheduler;

  localparam int RW   = 65;
  localparam int RMAX = 4;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [RW-1:0] rand_i;
  logic [2:0]    piece_o;
  logic          piece_valid_o;
  logic          piece_ready_i;
  logic [2:0]    preview_o;
  logic          preview_valid_o;
  logic [2:0]    bag_count_o;

  int checks   = 0;
  int failures = 0;

  int mq[$];
  bit used[7];
  int m_retry;

  piece_bag_scheduler #(
    .rand_width_p (RW),
    .sel_lsb_p    (0),
    .retry_max_p  (RMAX)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .rand_i          (rand_i),
    .piece_o         (piece_o),
    .piece_valid_o   (piece_valid_o),
    .piece_ready_i   (piece_ready_i),
    .preview_o       (preview_o),
    .preview_valid_o (preview_valid_o),
    .bag_count_o     (bag_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== 32'(exp)) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < 7; k++) n += int'(used[k]);
    return n;
  endfunction

  task automatic check_outputs();
    chk("valid", {31'd0, piece_valid_o}, int'(mq.size() > 0));
    chk("pvalid", {31'd0, preview_valid_o}, int'(mq.size() > 1));
    chk("count", {29'd0, bag_count_o}, m_count());
    chk("retry", {28'd0, dut.r_retry}, m_retry);
    if (mq.size() > 0) chk("piece", {29'd0, piece_o}, mq[0]);
    if (mq.size() > 1) chk("preview", {29'd0, preview_o}, mq[1]);
  endtask

  // One clock edge of the bag rules applied to the model.
  task automatic model_edge(input int c, input bit rdy);
    bit pop;
    bit draw;
    int pc;
    pop  = rdy && (mq.size() > 0);
    draw = (mq.size() < 2) || pop;
    pc   = -1;
    if (draw) begin
      if (m_retry == RMAX) begin
        for (int k = 6; k >= 0; k--) if (!used[k]) pc = k;
      end else if (c < 7) begin
        if (!used[c]) pc = c;
      end
    end
    if (pop) void'(mq.pop_front());
    if (pc >= 0) begin
      mq.push_back(pc);
      used[pc] = 1'b1;
      if (m_count() == 7) for (int k = 0; k < 7; k++) used[k] = 1'b0;
      m_retry = 0;
    end else if (draw) begin
      m_retry++;
    end
  endtask

  task automatic step(input int c, input bit rdy);
    logic [95:0] w;
    check_outputs();
    w = {$urandom(), $urandom(), $urandom()};
    rand_i = {w[64:3], 3'(c)};
    piece_ready_i = rdy;
    model_edge(c, rdy);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_n_i = 1'b0;
    mq.delete();
    for (int k = 0; k < 7; k++) used[k] = 1'b0;
    m_retry = 0;
    #1;
    chk("rst_piece", {29'd0, piece_o}, 0);
    chk("rst_valid", {31'd0, piece_valid_o}, 0);
    chk("rst_preview", {29'd0, preview_o}, 0);
    chk("rst_pvalid", {31'd0, preview_valid_o}, 0);
    chk("rst_count", {29'd0, bag_count_o}, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    reset_n_i     = 1'b0;
    piece_ready_i = 1'b0;
    rand_i        = '0;
    @(negedge clk_i);

    // Release with candidate 3 and ready low, then fill preview, then stall.
    do_reset();
    step(3, 1'b0);
    step(5, 1'b0);
    step(1, 1'b0);
    step(2, 1'b0);

    // Out-of-range rejections followed by an accept.
    do_reset();
    repeat (3) step(7, 1'b1);
    step(5, 1'b1);
    step(2, 1'b1);

    // Forced pick after retry_max rejections.
    do_reset();
    step(0, 1'b1);
    step(1, 1'b1);
    step(2, 1'b1);
    repeat (6) step(0, 1'b1);

    // Full bag in reverse order, then a fresh bag starts.
    do_reset();
    for (int p = 6; p >= 0; p--) step(p, 1'b1);
    step(6, 1'b1);
    step(6, 1'b1);

    // Backpressure: full queue freezes state regardless of rand_i.
    do_reset();
    step(2, 1'b0);
    step(4, 1'b0);
    repeat (10) step(int'($urandom_range(0, 7)), 1'b0);
    step(6, 1'b1);
    step(1, 1'b0);
    step(1, 1'b0);

    // Asynchronous reset between edges with two queued pieces and four drawn.
    do_reset();
    step(0, 1'b1);
    step(1, 1'b1);
    step(2, 1'b1);
    step(3, 1'b0);
    check_outputs();
    chk("mid_full", {31'd0, piece_valid_o & preview_valid_o}, 1);
    chk("mid_count", {29'd0, bag_count_o}, 4);
    #2;
    do_reset();

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      step(int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      if ((n % 700) == 699) do_reset();
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piece_bag_scheduler.md
# piece_bag_scheduler

Sequences the free-running LFSR random word into a fair 7-bag stream of Tetris pieces for the game logic. Each cycle it samples three bits of the random word and rejects values that are out of range or already drawn in the current bag. A bounded-retry fallback guarantees a worst-case draw latency. Accepted pieces go into a 2-entry queue, which exposes the current piece through a valid/ready handshake and the following piece as a preview.

## Interface
Parameters:
- rand_width_p, 65: width of rand_i; matches the random generator width.
- sel_lsb_p, 0: LSB index of the 3-bit candidate field within rand_i; legal range 0..rand_width_p-3.
- retry_max_p, 4: number of consecutive rejections before a forced pick; legal range 1..15.

Ports:
- clk_i, input, 1: single clock; all state changes on the rising edge.
- reset_n_i, input, 1: asynchronous, active-low reset.
- rand_i, input, rand_width_p: random word from the random generator, sampled every cycle.
- piece_o, output, 3: head piece, type piece_e.
- piece_valid_o, output, 1: head entry present.
- piece_ready_i, input, 1: consumer takes the head when piece_valid_o and piece_ready_i are both high.
- preview_o, output, 3: second queue entry.
- preview_valid_o, output, 1: second queue entry present.
- bag_count_o, output, 3: pieces accepted so far in the current bag, 0..6.

## Operation
- State held:
  - bag_used_r[6:0]: one bit per piece, set when that piece is accepted.
  - retry_r[3:0]: consecutive rejection count.
  - 2-entry FIFO with occupancy 0..2.
  - FSM with two states, S_DRAW and S_FULL.
- S_DRAW (occupancy < 2, or a pop is happening this cycle):
  - The candidate c is rand_i[sel_lsb_p+2:sel_lsb_p].
  - Accept if c != 7 and bag_used_r[c] == 0.
  - Forced pick: if retry_r == retry_max_p, accept the lowest-indexed clear bit of bag_used_r, ignoring c.
  - On accept: push the piece, set its bag_used_r bit, clear retry_r.
  - On reject: retry_r increments.
- Bag completion: when the accept fills the 7th bit, bag_used_r clears to 0 on the same edge. bag_count_o then reads 0 and never shows 7.
- S_FULL (occupancy == 2 and no pop):
  - No draw is made.
  - bag_used_r, retry_r and bag_count_o hold.
  - rand_i is ignored.
- FSM transitions:
  - S_DRAW goes to S_FULL when a push brings occupancy to 2 with no pop.
  - S_FULL goes to S_DRAW on a pop.
- Simultaneous pop and push:
  - When full: the head is popped, the preview shifts to the head, and the new piece enters the preview slot in the same edge. Occupancy stays 2.
  - When occupancy is 1: the new piece becomes the head and occupancy stays 1.
- Popping with piece_valid_o low has no effect.
- bag_count_o is the popcount of bag_used_r.

## Timing
- Reset values while reset_n_i is low:
  - piece_o = 0, piece_valid_o = 0, preview_o = 0, preview_valid_o = 0, bag_count_o = 0.
  - bag_used_r = 0, retry_r = 0, FSM in S_DRAW.
- Reset takes effect asynchronously, mid-operation included: all queued and bag state is discarded at once.
- Draw latency:
  - An accepted candidate appears on piece_o/preview_o one cycle after it is sampled (registered push).
  - Worst-case time from a slot freeing to a piece becoming visible is retry_max_p+1 cycles.
- Outputs are registered; none depends combinationally on piece_ready_i or rand_i.
- Throughput: one piece per cycle sustained while piece_ready_i is held high.

## Structure
- Package tetris_pkg holds:
  - typedef enum logic [2:0] piece_e: I=0, O=1, T=2, S=3, Z=4, J=5, L=6.
  - localparam num_pieces_lp = 7.
  - FSM state typedef.
- Sub-module piece_queue: 2-entry FIFO with push/pop, head/second outputs and valids.
- The top level keeps the bag mask, retry counter, candidate/forced-pick logic and FSM.

## Test plan
All scenarios drive rand_i directly from the bench, with sel_lsb_p = 0.

- Reset release with rand_i[2:0] = 3 and ready low:
  - Cycle after release: piece_o = 3, piece_valid_o = 1, bag_count_o = 1.
  - Next cycle: a second candidate fills preview_o.
- Out-of-range rejection: rand_i[2:0] = 7 for 3 cycles, then 5 → piece 5 accepted on the 4th sample, retry_r back to 0.
- Forced pick: pieces 0, 1, 2 already drawn, rand_i[2:0] held at 0, retry_max_p = 4 → 4 rejections, then forced piece 3 on the 5th cycle.
- Bag completion with ready high: feed 6, 5, 4, 3, 2, 1, 0 → all 7 accepted; bag_count_o goes 1..6, then 0; a following candidate 6 is accepted.
- Backpressure with ready low:
  - Queue fills with two pieces; bag_count_o and retry_r freeze for 10 cycles regardless of rand_i.
  - One cycle of ready high with a valid candidate: pop and push on the same edge, occupancy stays 2, and the preview moves to the head.
- Asynchronous reset mid-stream: assert reset_n_i between clock edges with occupancy 2 and bag_count_o = 4 → all outputs are 0 immediately, before the next edge.
